led_seq_ctrl: RTL
=================

# led_seq_ctrl

Command-driven sequencer for the 4-bit LED bank. It accepts a pattern command through a valid/ready handshake and steps the selected pattern at a programmable rate for a requested number of passes. It then reports completion and returns the LEDs dark. It sits between the board-level control logic and the `led` pins, and takes over the role of the free-running LED driver.

## Interface
Parameters:
- `TICK_DIV`, default 5: clock cycles each pattern step is held. Legal range is 2..2^16-1.
- `CNT_W`, default 16: prescaler counter width. Must satisfy TICK_DIV ≤ 2^CNT_W − 1.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_mode`, in, 2: pattern select. 0 = run-left, 1 = run-right, 2 = blink, 3 = fill-bar.
- `cmd_reps`, in, 4: number of passes. 0 means continuous.
- `stop`, in, 1: abort the running sequence.
- `led`, out, 4: LED drive, registered.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle completion pulse.
- `pause`, in, 1: only present with `LED_SEQ_PAUSE_EN` (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `cmd_ready`=1, `busy`=0, `led`=0000.
  - On handshake: latch mode and reps, clear the prescaler, step index and pass counter, load step-0 pattern into `led`, go to RUN.
  - `stop` is ignored in IDLE.
- RUN:
  - `cmd_ready`=0 and `busy`=1. `cmd_valid` is ignored and latched fields do not change.
  - Prescaler counts 0..TICK_DIV−1. At TICK_DIV−1 it wraps to 0 and the step index advances.
  - Step index is 2 bits and wraps 3→0. Each wrap completes one pass.
- Patterns for steps 0..3:
  - Mode 0: 0001, 0010, 0100, 1000.
  - Mode 1: 1000, 0100, 0010, 0001.
  - Mode 2: 1111, 0000, 1111, 0000.
  - Mode 3: 0001, 0011, 0111, 1111.
- Pass counter is 4 bits.
  - When reps≠0 and the pass that completes equals reps: go to DONE instead of wrapping.
  - When reps=0: passes repeat indefinitely and the counter does not advance.
- `stop` high in RUN: go to DONE on the next edge, regardless of step position.
  - If `stop` coincides with the final step's end, only one DONE occurs.
- DONE: lasts exactly one cycle. `done`=1, `led`=0000, `busy`=0, `cmd_ready`=0. Always goes to IDLE next.
- Reset values: state IDLE, `led`=0000, `busy`=0, `done`=0, `cmd_ready`=1 from the first cycle after reset. Prescaler, step index and pass counter are all 0.
- `rst` during RUN or DONE: abandons the sequence with no `done` pulse.

## Timing
- Handshake at edge T means step 0 appears on `led` from T+1 and holds for TICK_DIV cycles. Step k covers cycles T+1+k·TICK_DIV through T+(k+1)·TICK_DIV.
- A finite command lasts 4·reps·TICK_DIV cycles in RUN. `done` is high in the cycle after the last step. `cmd_ready` returns one cycle after that.
- Minimum spacing between accepted commands is 4·reps·TICK_DIV + 2 cycles.
- `stop` sampled at edge S gives `done`=1 and `led`=0000 from S+1.
- `cmd_ready` is decoded from the state register only, with no combinational path from `cmd_valid`.

## Configuration
- `LED_SEQ_PAUSE_EN` defined:
  - Adds the `pause` input port.
  - While `pause`=1 in RUN, the prescaler, step index and pass counter freeze and `led` holds its value.
  - `stop` takes priority over `pause`.
  - Counting resumes the cycle after `pause` falls, with no step lost.
  - `pause` has no effect in IDLE or DONE.
- `LED_SEQ_PAUSE_EN` undefined: the `pause` port and freeze logic are absent, and RUN always advances.

## Test plan
All scenarios use TICK_DIV=5.
- Reset: `rst`=1 for 2 cycles → `led`=0000, `busy`=0, `done`=0, `cmd_ready`=1.
- Mode 0, reps=1, accepted at T → `led` is 0001 for T+1..T+5, 0010 for T+6..T+10, 0100 for T+11..T+15, 1000 for T+16..T+20. Then `done`=1 with `led`=0000 at T+21, and `cmd_ready`=1 at T+22.
- Mode 3, reps=2, with `cmd_valid` held high throughout RUN → 0001/0011/0111/1111 twice over 40 cycles, and a single `done` at T+41. The second command is taken only when `cmd_ready` is back at 1, at T+42.
- Mode 2, reps=0 → 1111/0000 toggles every 5 cycles for more than 200 cycles with no `done`. `stop` at S → `done`=1 and `led`=0000 at S+1, then IDLE.
- `rst` asserted at T+8 of a mode-1 sequence → at T+9 `led`=0000, `busy`=0, `cmd_ready`=1, and no `done` is ever seen.
- With `LED_SEQ_PAUSE_EN`: `pause` held 7 cycles during step 1 of mode 0, reps=1 → step 1 lasts 12 cycles and `done` arrives at T+28.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Command-driven LED pattern sequencer: IDLE -> RUN (steps a pattern for N passes) -> DONE pulse.
// Optional pause/freeze input is enabled by defining LED_SEQ_PAUSE_EN.
module led_seq_ctrl #(
    parameter int TICK_DIV = 5,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_reps,
    input  logic       stop,
`ifdef LED_SEQ_PAUSE_EN
    input  logic       pause,
`endif
    output logic [3:0] led,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LP_TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_nxt;
    logic [1:0]       r_step;
    logic [1:0]       w_step_nxt;
    logic [1:0]       w_step_inc;
    logic [3:0]       r_pass;
    logic [3:0]       w_pass_nxt;
    logic [3:0]       w_pass_inc;
    logic [1:0]       r_mode;
    logic [3:0]       r_reps;
    logic [3:0]       r_led;
    logic [3:0]       w_led_nxt;
    logic             w_tick_end;
    logic             w_pass_end;
    logic             w_last_pass;
    logic             w_hold;
    logic             w_accept;

    function automatic logic [3:0] f_pattern(input logic [1:0] mode, input logic [1:0] step);
        logic [3:0] pat;
        case (mode)
            2'd0:    pat = 4'b0001 << step;
            2'd1:    pat = 4'b1000 >> step;
            2'd2:    pat = step[0] ? 4'b0000 : 4'b1111;
            default: pat = 4'b1111 >> (2'd3 - step);
        endcase
        return pat;
    endfunction

`ifdef LED_SEQ_PAUSE_EN
    assign w_hold = pause;
`else
    assign w_hold = 1'b0;
`endif

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_tick_end  = (r_presc == LP_TICK_LAST);
    assign w_step_inc  = r_step + 2'd1;
    assign w_pass_inc  = r_pass + 4'd1;
    assign w_pass_end  = w_tick_end && (r_step == 2'd3);
    // reps == 0 means continuous, so the pass counter never reaches a finish.
    assign w_last_pass = (r_reps != 4'd0) && (w_pass_inc == r_reps);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_step_nxt  = r_step;
        w_pass_nxt  = r_pass;
        w_led_nxt   = r_led;
        case (r_state)
            S_IDLE: begin
                w_led_nxt = 4'b0000;
                if (cmd_valid) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = '0;
                    w_step_nxt  = 2'd0;
                    w_pass_nxt  = 4'd0;
                    w_led_nxt   = f_pattern(cmd_mode, 2'd0);
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_DONE;
                    w_led_nxt   = 4'b0000;
                end else if (!w_hold) begin
                    if (!w_tick_end) begin
                        w_presc_nxt = r_presc + 1'b1;
                    end else if (w_pass_end && w_last_pass) begin
                        w_presc_nxt = '0;
                        w_state_nxt = S_DONE;
                        w_led_nxt   = 4'b0000;
                    end else begin
                        w_presc_nxt = '0;
                        w_step_nxt  = w_step_inc;
                        w_led_nxt   = f_pattern(r_mode, w_step_inc);
                        if (w_pass_end && (r_reps != 4'd0))
                            w_pass_nxt = w_pass_inc;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_led_nxt   = 4'b0000;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_led_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_step  <= 2'd0;
            r_pass  <= 4'd0;
            r_led   <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_step  <= w_step_nxt;
            r_pass  <= w_pass_nxt;
            r_led   <= w_led_nxt;
        end
    end

    // Command fields only change on a handshake, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mode <= cmd_mode;
            r_reps <= cmd_reps;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign led       = r_led;

endmodule
